// File: rtl/command_scheduler.sv
// command_scheduler: sequences decoded host commands onto the core memory port.
// Optional ack timeout enabled by defining SCHED_TIMEOUT_EN.
module command_scheduler #(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  input  logic [7:0]               cmd_instr_i,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr_i,
  input  logic [VALUE_WIDTH-1:0]   cmd_value_i,
  output logic                     cmd_ready_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [VALUE_WIDTH-1:0]   mem_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [VALUE_WIDTH-1:0]   mem_rdata_i,
  output logic [VALUE_WIDTH-1:0]   result_o,
  output logic [VALUE_WIDTH-1:0]   stream_o,
  output logic                     irq_o,
  output logic                     err_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_STREAM_WR = 3'd3;
  localparam logic [2:0] S_STREAM_RD = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]               state_q, state_d;
  logic                     req_q, req_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [VALUE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [VALUE_WIDTH-1:0]   result_q, result_d;
  logic [VALUE_WIDTH-1:0]   stream_q, stream_d;
  logic                     irq_q, irq_d;
  logic                     err_q, err_d;
  logic                     hit_q, hit_d;
  logic [ADDRESS_WIDTH-1:0] bind_rd_q, bind_rd_d;
  logic [ADDRESS_WIDTH-1:0] bind_wr_q, bind_wr_d;
  logic [ADDRESS_WIDTH-1:0] irq_addr_q, irq_addr_d;
  logic                     ack;

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  assign ack = req_q & mem_ack_i;

  // next-state, bus phase and capture decisions
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    stream_d   = stream_q;
    irq_d      = 1'b0;
    err_d      = err_q;
    hit_d      = hit_q;
    bind_rd_d  = bind_rd_q;
    bind_wr_d  = bind_wr_q;
    irq_addr_d = irq_addr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          unique case (1'b1)
            cmd_instr_i == 8'd1: begin
              state_d = S_WRITE;
              req_d   = 1'b1;
              we_d    = 1'b1;
              addr_d  = cmd_addr_i;
              wdata_d = cmd_value_i;
              hit_d   = cmd_addr_i == irq_addr_q;
            end
            cmd_instr_i == 8'd2: begin
              state_d = S_READ;
              req_d   = 1'b1;
              we_d    = 1'b0;
              addr_d  = cmd_addr_i;
              hit_d   = 1'b0;
            end
            cmd_instr_i == 8'd3: begin
              state_d = S_STREAM_WR;
              req_d   = 1'b1;
              we_d    = 1'b1;
              addr_d  = bind_wr_q;
              wdata_d = cmd_value_i;
              hit_d   = bind_wr_q == irq_addr_q;
            end
            cmd_instr_i == 8'd4: irq_addr_d = cmd_addr_i;
            cmd_instr_i == 8'd5: bind_rd_d  = cmd_addr_i;
            cmd_instr_i == 8'd6: bind_wr_d  = cmd_addr_i;
            cmd_instr_i == 8'd7: ;
            cmd_instr_i == 8'd8: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      S_WRITE, S_READ: begin
        if (ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          irq_d   = hit_q;
          if (state_q == S_READ) result_d = mem_rdata_i;
        end
      end
      S_STREAM_WR: begin
        if (ack) begin
          state_d = S_STREAM_RD;
          we_d    = 1'b0;
          addr_d  = bind_rd_q;
        end
      end
      S_STREAM_RD: begin
        if (ack) begin
          state_d  = S_DONE;
          req_d    = 1'b0;
          irq_d    = hit_q;
          stream_d = mem_rdata_i;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
    if (cmd_valid_i && state_q != S_IDLE) err_d = 1'b1;
`ifdef SCHED_TIMEOUT_EN
    cnt_d = (!req_q || mem_ack_i) ? 32'd0 : cnt_q + 32'd1;
    if (req_q && !mem_ack_i && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_DONE;
      req_d   = 1'b0;
      irq_d   = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end

  // state registers with asynchronous abort on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      stream_q   <= '0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      bind_rd_q  <= '0;
      bind_wr_q  <= '0;
      irq_addr_q <= '0;
`ifdef SCHED_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      stream_q   <= stream_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      bind_rd_q  <= bind_rd_d;
      bind_wr_q  <= bind_wr_d;
      irq_addr_q <= irq_addr_d;
`ifdef SCHED_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign cmd_ready_o = state_q == S_IDLE;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign result_o    = result_q;
  assign stream_o    = stream_q;
  assign irq_o       = irq_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_command_scheduler.sv
// tb_command_scheduler: transaction-level model plus directed and random
// command streams against command_scheduler.
module tb_command_scheduler;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_instr = '0;
  logic [23:0] cmd_addr = '0;
  logic [31:0] cmd_value = '0;
  logic        cmd_ready;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] result, stream;
  logic        irq, err;

  command_scheduler #(
    .ADDRESS_WIDTH(24),
    .VALUE_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_instr_i(cmd_instr),
    .cmd_addr_i(cmd_addr),
    .cmd_value_i(cmd_value),
    .cmd_ready_o(cmd_ready),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata),
    .result_o(result),
    .stream_o(stream),
    .irq_o(irq),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memdef(logic [23:0] a);
    return 32'hA5A50000 ^ {8'h00, a};
  endfunction

  // ---------------- memory responder (environment) ----------------
  logic [31:0] rmem [logic [23:0]];
  int force_dly = -1;
  int dly = -1;

  function automatic logic [31:0] rlook(logic [23:0] a);
    return rmem.exists(a) ? rmem[a] : memdef(a);
  endfunction

  always @(posedge clk) begin
    #2;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req && rst_n) begin
      if (dly < 0) dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
      if (dly == 0) begin
        mem_ack = 1'b1;
        if (mem_we) rmem[mem_addr] = mem_wdata;
        else mem_rdata = rlook(mem_addr);
        dly = -1;
      end else begin
        dly--;
      end
    end else begin
      dly = -1;
      if ($urandom_range(0, 9) == 0) mem_ack = 1'b1;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        we;
    logic        strm;
    logic [23:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        q[$];
  logic [31:0] emem [logic [23:0]];
  logic        busy = 1'b0;
  int          done_cnt = 0;
  int          pcnt = 0;
  logic        cmd_hit = 1'b0;
  logic [31:0] result_e = '0, stream_e = '0;
  logic        irq_e = 1'b0, err_e = 1'b0;
  logic [23:0] brd = '0, bwr = '0, birq = '0;
  int          irq_cnt = 0;

  function automatic logic [31:0] elook(logic [23:0] a);
    return emem.exists(a) ? emem[a] : memdef(a);
  endfunction

  task automatic preload(logic [23:0] a, logic [31:0] v);
    rmem[a] = v;
    emem[a] = v;
  endtask

  // compare DUT against the model, then advance the model across the next edge
  always @(negedge clk) begin
    txn_t t;
    if (!rst_n) begin
      q.delete();
      busy = 1'b0; done_cnt = 0; pcnt = 0; cmd_hit = 1'b0;
      result_e = '0; stream_e = '0; irq_e = 1'b0; err_e = 1'b0;
      brd = '0; bwr = '0; birq = '0;
    end
    if (irq) irq_cnt++;
    chk("ready", cmd_ready, !busy);
    chk("req", mem_req, q.size() != 0);
    if (q.size() != 0) begin
      chk("addr", mem_addr, q[0].a);
      chk("we", mem_we, q[0].we);
      if (q[0].we) chk("wdata", mem_wdata, q[0].d);
    end
    chk("result", result, result_e);
    chk("stream", stream, stream_e);
    chk("irq", irq, irq_e);
    chk("err", err, err_e);
    if (rst_n) begin
      irq_e = 1'b0;
      if (q.size() != 0) begin
        if (mem_ack) begin
          t = q.pop_front();
          pcnt = 0;
          if (t.we) emem[t.a] = t.d;
          else if (t.strm) stream_e = elook(t.a);
          else result_e = elook(t.a);
          if (q.size() == 0) begin
            done_cnt = 2;
            irq_e = cmd_hit;
          end
        end
`ifdef SCHED_TIMEOUT_EN
        else begin
          pcnt++;
          if (pcnt == TO) begin
            q.delete();
            pcnt = 0;
            done_cnt = 2;
            err_e = 1'b1;
          end
        end
`endif
      end
      if (cmd_valid) begin
        if (busy) begin
          err_e = 1'b1;
        end else begin
          case (cmd_instr)
            8'd1: begin
              q.push_back('{1'b1, 1'b0, cmd_addr, cmd_value});
              cmd_hit = cmd_addr == birq;
              busy = 1'b1;
            end
            8'd2: begin
              q.push_back('{1'b0, 1'b0, cmd_addr, 32'h0});
              cmd_hit = 1'b0;
              busy = 1'b1;
            end
            8'd3: begin
              q.push_back('{1'b1, 1'b0, bwr, cmd_value});
              q.push_back('{1'b0, 1'b1, brd, 32'h0});
              cmd_hit = bwr == birq;
              busy = 1'b1;
            end
            8'd4: birq = cmd_addr;
            8'd5: brd = cmd_addr;
            8'd6: bwr = cmd_addr;
            8'd7, 8'd8: ;
            default: err_e = 1'b1;
          endcase
          pcnt = 0;
        end
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(logic [7:0] op, logic [23:0] a, logic [31:0] v);
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_instr = op;
    cmd_addr  = a;
    cmd_value = v;
  endtask

  task automatic idle_cmd();
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", cmd_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int r;
    logic [7:0] op;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // reset aborts an outstanding READ
    force_dly = 100;
    drive(8'd2, 24'h50, 32'h0);
    idle_cmd();
    @(negedge clk);
    chk("mid_req_high", mem_req, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_req_low", mem_req, 1'b0);
    chk("abort_result", result, 32'h0);
    force_dly = -1;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ready();

    // WRITE held until a delayed ack
    force_dly = 2;
    drive(8'd1, 24'h10, 32'hDEADBEEF);
    idle_cmd();
    n = 0;
    @(negedge clk);
    while (!(mem_req && mem_ack) && n < 20) begin
      chk("wr_hold_addr", mem_addr, 24'h10);
      chk("wr_hold_data", mem_wdata, 32'hDEADBEEF);
      @(negedge clk);
      n++;
    end
    chk("wr_acked", mem_req && mem_ack, 1'b1);
    force_dly = -1;
    @(negedge clk);
    chk("wr_done_ready", cmd_ready, 1'b0);
    @(negedge clk);
    chk("wr_ready_back", cmd_ready, 1'b1);
    chk("wr_mem", rlook(24'h10), 32'hDEADBEEF);

    // bound stream, back-to-back with its binds
    do_reset();
    preload(24'h30, 32'hCAFEF00D);
    drive(8'd6, 24'h20, 32'h0);
    drive(8'd5, 24'h30, 32'h0);
    drive(8'd3, 24'h0, 32'h12345678);
    idle_cmd();
    wait_ready();
    chk("stream_val", stream, 32'hCAFEF00D);
    chk("stream_wr", rlook(24'h20), 32'h12345678);

    // interrupt on a write to the bound address only
    drive(8'd4, 24'h40, 32'h0);
    idle_cmd();
    base = irq_cnt;
    drive(8'd1, 24'h40, 32'h1);
    idle_cmd();
    wait_ready();
    @(negedge clk);
    chk("irq_once", irq_cnt - base, 1);
    base = irq_cnt;
    drive(8'd1, 24'h41, 32'h2);
    idle_cmd();
    wait_ready();
    @(negedge clk);
    chk("irq_none", irq_cnt - base, 0);

    // command dropped while busy
    do_reset();
    chk("drop_err0", err, 1'b0);
    force_dly = 4;
    drive(8'd2, 24'h60, 32'h0);
    idle_cmd();
    drive(8'd1, 24'h61, 32'h5);
    idle_cmd();
    wait_ready();
    force_dly = -1;
    chk("drop_err1", err, 1'b1);
    chk("drop_nobus", rmem.exists(24'h61), 1'b0);

    // illegal opcode
    do_reset();
    drive(8'd9, 24'h0, 32'h0);
    idle_cmd();
    @(negedge clk);
    chk("bad_op_err", err, 1'b1);

`ifdef SCHED_TIMEOUT_EN
    do_reset();
    force_dly = 100;
    drive(8'd2, 24'h70, 32'h0);
    idle_cmd();
    n = 0;
    @(negedge clk);
    while (mem_req && n < 30) begin
      n++;
      @(negedge clk);
    end
    force_dly = -1;
    chk("to_cycles", n, TO);
    chk("to_err", err, 1'b1);
    chk("to_result", result, 32'h0);
    wait_ready();
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r < 5) op = 8'd1;
      else if (r < 9) op = 8'd2;
      else if (r < 12) op = 8'd3;
      else if (r == 12) op = 8'd4;
      else if (r == 13) op = 8'd5;
      else if (r == 14) op = 8'd6;
      else if (r == 15) op = 8'($urandom_range(7, 8));
      else if (r == 16) op = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255));
      else op = 8'($urandom_range(1, 2));
      if ($urandom_range(0, 7) != 0) wait_ready();
      drive(op, 24'($urandom_range(0, 15)), $urandom);
      idle_cmd();
    end
    wait_ready();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/command_scheduler.md
# command_scheduler

Sequences decoded host commands onto the shared core memory port. Sits between the SPI instruction decoder (instruction/address/value outputs) and the core's word-addressed memory bus. Owns the bound stream read/write addresses and the interrupt address, and produces the `result` and `stream` words the decoder shifts back out over SPI. One command is in flight at a time; commands arriving while busy are dropped and flagged.

## Interface
- `ADDRESS_WIDTH`, 24, memory address width
- `VALUE_WIDTH`, 32, data word width
- `TIMEOUT_CYCLES`, 255, ack wait limit; used only when `SCHED_TIMEOUT_EN` is defined

- `clk_i`  in  1  clock; all logic on the rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `cmd_valid_i`  in  1  one-cycle pulse: the `cmd_*` inputs hold a new command
- `cmd_instr_i`  in  8  opcode: 1 WRITE, 2 READ, 3 STREAM, 4 BIND_INTERRUPT, 5 BIND_READ_ADDRESS, 6 BIND_WRITE_ADDRESS, 7 TRANSFER, 8 REPEAT
- `cmd_addr_i`  in  ADDRESS_WIDTH  command address
- `cmd_value_i`  in  VALUE_WIDTH  command value
- `cmd_ready_o`  out  1  high when in IDLE
- `mem_req_o`  out  1  bus request, held until ack
- `mem_we_o`  out  1  1 = write, 0 = read
- `mem_addr_o`  out  ADDRESS_WIDTH  bus address
- `mem_wdata_o`  out  VALUE_WIDTH  bus write data
- `mem_ack_i`  in  1  bus completion; read data is valid in the same cycle
- `mem_rdata_i`  in  VALUE_WIDTH  bus read data
- `result_o`  out  VALUE_WIDTH  last READ data
- `stream_o`  out  VALUE_WIDTH  last STREAM read-back data
- `irq_o`  out  1  one-cycle pulse
- `err_o`  out  1  sticky error; cleared only by reset

## Operation

**State machine:** IDLE, WRITE, READ, STREAM_WR, STREAM_RD, DONE.

**Command handling in IDLE**, on `cmd_valid_i`:
- opcode 1 → WRITE: `mem_addr_o` = addr, `mem_wdata_o` = value, `mem_we_o` = 1.
- opcode 2 → READ: `mem_addr_o` = addr, `mem_we_o` = 0.
- opcode 3 → STREAM_WR: `mem_addr_o` = `bind_wr`, `mem_wdata_o` = value, `mem_we_o` = 1.
- opcodes 4/5/6: load `irq_addr` / `bind_rd` / `bind_wr` with `cmd_addr_i`. No bus access; remain in IDLE.
- opcodes 7/8: no operation (handled by the SPI side); remain in IDLE.
- opcode 0 or opcode > 8: ignored; set `err_o`.

**Bus phases:**
- WRITE or READ with `mem_ack_i` → DONE. On READ, `result_o` is loaded with `mem_rdata_i`.
- STREAM_WR with ack → STREAM_RD: `mem_addr_o` = `bind_rd`, `mem_we_o` = 0.
- STREAM_RD with ack → DONE; `stream_o` is loaded with `mem_rdata_i`.
- DONE → IDLE unconditionally. DONE gives one idle bus cycle between transactions.

**Interrupt:** `irq_o` pulses during DONE when the completed command wrote address `irq_addr`, whether from WRITE or STREAM_WR.

**Drops:** `cmd_valid_i` while not in IDLE drops the command and sets `err_o`.

**Reset values:** state IDLE; `cmd_ready_o` = 1; every other output is 0; `bind_rd`, `bind_wr` and `irq_addr` are 0.

## Timing
- Command accepted at edge N: `mem_req_o` is high from N+1 and `cmd_ready_o` is low from N+1.
- `mem_req_o`, `mem_addr_o`, `mem_we_o` and `mem_wdata_o` are stable while waiting for ack.
- Ack sampled at edge M:
  - `mem_req_o` drops at M+1 for WRITE, READ and STREAM_RD.
  - For STREAM_WR, `mem_req_o` stays high and the address/direction switch at M+1.
- `result_o` and `stream_o` update at M+1. `cmd_ready_o` is high again at M+2.
- Minimum READ latency: command to `result_o` in 2 cycles when ack is immediate.
- A bind command at edge N takes effect at N+1. A STREAM at N+1 uses the new bound address.
- Reset asserted mid-transaction aborts immediately: `mem_req_o` = 0, no capture into `result_o` or `stream_o`.
- `mem_ack_i` outside an active request is ignored.

## Configuration
- **`SCHED_TIMEOUT_EN` defined:**
  - A counter runs while `mem_req_o` is high and clears on each new bus phase.
  - Reaching `TIMEOUT_CYCLES` without ack:
    - aborts to DONE and sets `err_o`;
    - captured register (`result_o` or `stream_o`) is unchanged;
    - no `irq_o`.
- **Undefined:** no counter; the scheduler waits indefinitely for ack.

## Test plan
- After reset, all outputs are 0 and `cmd_ready_o` = 1. Assert `rst_ni` low while in READ → `mem_req_o` falls asynchronously and `result_o` stays 0.
- WRITE addr 0x000010 value 0xDEADBEEF with ack after 3 cycles → one write with exactly those address/data held throughout. `cmd_ready_o` returns high 2 cycles after the ack.
- BIND_WRITE_ADDRESS 0x20, then BIND_READ_ADDRESS 0x30, then STREAM 0x12345678, memory[0x30] = 0xCAFEF00D → write 0x12345678 to 0x20, then read from 0x30. `stream_o` = 0xCAFEF00D.
- BIND_INTERRUPT 0x40, then WRITE 0x40 value 1 → `irq_o` pulses exactly once. A WRITE to 0x41 gives no `irq_o`.
- READ accepted, second `cmd_valid_i` (WRITE) while waiting for ack → second command never reaches the bus and `err_o` = 1. Opcode 0x09 from a fresh reset also gives `err_o` = 1.
- With `SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, READ with no ack → `mem_req_o` drops after 8 request cycles, `err_o` = 1, `result_o` is unchanged.
